prog_load_arbiter: RTL and testbench
====================================

// Module: prog_load_arbiter
// PURPOSE
//  Shares the 16x8 program RAM between the running CPU and an external host loader.
//  While idle, the CPU owns the RAM address, data and write-enable path.
//  On a host load request, the block waits for an instruction boundary (or CPU halt).
//  It then freezes the CPU clock, hands the RAM to the host and accepts byte writes.
//  On release it pulses the program-counter reset so the new program starts at address 0.
// PARAMETERS
//  ADDR_W      4   RAM address width (depth = 2**ADDR_W)
//  DATA_W      8   RAM data width
//  RST_CYCLES  2   cycles pc_rst is held high on release (>=1)
//  DRAIN_MAX   15  cycles to wait for a boundary before forcing the grant
// PORTS
//  clk         in   1       system clock; all state updates on rising edge
//  rst         in   1       async, active-high reset
//  load_req    in   1       host requests RAM ownership (level; drop to release)
//  host_valid  in   1       host write strobe; transfer when host_valid & host_ready
//  host_addr   in   ADDR_W  host write address
//  host_data   in   DATA_W  host write data
//  host_ready  out  1       high only in LOAD state
//  load_grant  out  1       high while the host owns the RAM (LOAD state)
//  load_count  out  ADDR_W+1  number of bytes written in current session; saturates at 2**ADDR_W
//  cpu_boundary in  1       CPU is at T0 of fetch (instruction boundary)
//  cpu_halted  in   1       CPU HLT asserted; treated as a boundary
//  cpu_addr    in   ADDR_W  CPU memory address register value
//  cpu_wdata   in   DATA_W  CPU bus data toward RAM
//  cpu_we      in   1       CPU RAM write enable (RI)
//  cpu_hold    out  1       gate CPU clock (combine as clk & ~HLT & ~cpu_hold)
//  pc_rst      out  1       program-counter reset pulse
//  ram_addr    out  ADDR_W  muxed RAM address
//  ram_wdata   out  DATA_W  muxed RAM write data
//  ram_we      out  1       muxed RAM write enable
// BEHAVIOUR
//  Reset: state = IDLE; load_count = 0; host_ready, load_grant, cpu_hold and pc_rst = 0.
//  Reset is async; it aborts any state, including mid-LOAD, with no partial release pulse.
//  States and transitions (one transition per clk):
//   IDLE:    load_req=1 -> DRAIN.
//   DRAIN:   cpu_hold=1 is asserted combinationally as soon as cpu_boundary|cpu_halted is seen.
//            On that cycle -> LOAD.
//            A drain counter runs from 0; at DRAIN_MAX -> LOAD (forced grant).
//            load_req=0 while in DRAIN -> IDLE; no pc_rst pulse.
//   LOAD:    cpu_hold=1, load_grant=1, host_ready=1; load_count is cleared on entry.
//            Each host_valid cycle gives ram_we=1, ram_addr=host_addr, ram_wdata=host_data
//            (combinational, written on the same edge), and load_count+1 (saturating).
//            load_req=0 -> RELEASE; a host_valid in that same cycle is still written.
//   RELEASE: cpu_hold=1, pc_rst=1 for RST_CYCLES cycles, then -> IDLE.
//            On the IDLE entry edge cpu_hold=0.
//            load_req=1 during RELEASE is ignored until IDLE, then re-requests.
//  RAM mux:
//   In IDLE, ram_* = cpu_*.
//   In DRAIN, ram_* = cpu_* and cpu_we passes through; the CPU is still clocked until hold.
//   In LOAD and RELEASE, CPU inputs are ignored; ram_we=0 unless a host transfer is occurring.
//  Addresses wrap naturally at ADDR_W; writing the same address twice keeps the last value.
//  load_count holds its value through RELEASE and IDLE until the next LOAD entry.
//  Latency: request to grant is 1 cycle minimum (boundary present), DRAIN_MAX+1 maximum.
// STRUCTURE
//  A shared package holds the state encoding localparams (IDLE, DRAIN, LOAD, RELEASE),
//  ADDR_W and DATA_W defaults.
//  One sub-module, arb_cycle_counter: a loadable down-counter reused for the drain timeout
//  and the RST_CYCLES pulse.
//  FSM and mux are in the top; outputs are registered except ram_*, cpu_hold and host_ready.
// TESTING
//  1. Reset mid-LOAD, after 3 writes -> on the next edge, state=IDLE, load_count=0,
//     cpu_hold=0, pc_rst=0.
//  2. load_req with cpu_boundary=1 -> next cycle load_grant=1.
//     Write 0x1E to addr 0 and 0x2F to addr 1 -> RAM readback 1E/2F; load_count=2.
//  3. load_req with cpu_boundary=0 and cpu_halted=0 -> grant after exactly DRAIN_MAX+1 cycles.
//  4. Drop load_req -> pc_rst high for exactly 2 cycles, then cpu_hold=0 and ram_addr follows cpu_addr.
//  5. 17 host writes, including addr 0xF then 0x0 -> load_count saturates at 16;
//     addr 0 holds the last value written.
//  6. cpu_we=1 during LOAD with host_valid=0 -> ram_we=0, RAM unchanged.

Source files
------------

// File: rtl/prog_load_arbiter_pkg.sv
// Shared definitions for the program-load arbiter.
//  - arb_state_e : arbiter FSM state encoding (IDLE, DRAIN, LOAD, RELEASE)
//  - ADDR_W_DEF / DATA_W_DEF : default RAM geometry (16 x 8)
package prog_load_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StDrain   = 2'd1,
    StLoad    = 2'd2,
    StRelease = 2'd3
  } arb_state_e;

endpackage

// File: rtl/arb_cycle_counter.sv
// Loadable down-counter shared by the drain timeout and the pc_rst pulse length.
//  i_clk      : clock
//  i_rst      : async active-high reset (count -> 0)
//  i_load     : load i_load_val (takes priority over i_dec)
//  i_load_val : value to load
//  i_dec      : decrement by one, holding at zero
//  o_zero     : count is zero
module arb_cycle_counter #(
  parameter int unsigned W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/prog_load_arbiter.sv
// Arbitrates the program RAM between the CPU and an external host loader.
// A host request waits for an instruction boundary (or halt, or a drain timeout), freezes the
// CPU, lets the host write bytes, then pulses the PC reset on release.
//  i_clk, i_rst              : clock, async active-high reset
//  i_load_req                : host ownership request (level)
//  i_host_valid/addr/data    : host write strobe, address, data
//  o_host_ready, o_load_grant: host may write (LOAD state)
//  o_load_count              : bytes written this session, saturating at 2**ADDR_W
//  i_cpu_boundary/halted     : CPU at fetch T0 / halted
//  i_cpu_addr/wdata/we       : CPU-side RAM signals
//  o_cpu_hold                : CPU clock gate
//  o_pc_rst                  : program-counter reset pulse
//  o_ram_addr/wdata/we       : muxed RAM signals
module prog_load_arbiter
  import prog_load_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned DRAIN_MAX  = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load_req,
  input  logic              i_host_valid,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_data,
  output logic              o_host_ready,
  output logic              o_load_grant,
  output logic [ADDR_W:0]   o_load_count,
  input  logic              i_cpu_boundary,
  input  logic              i_cpu_halted,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  input  logic              i_cpu_we,
  output logic              o_cpu_hold,
  output logic              o_pc_rst,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_ram_we
);

  localparam int unsigned CntMax = (DRAIN_MAX > RST_CYCLES) ? DRAIN_MAX : RST_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned Depth  = 1 << ADDR_W;

  arb_state_e          r_state;
  arb_state_e          w_state_d;
  logic                r_load_grant;
  logic                r_pc_rst;
  logic [ADDR_W:0]     r_load_count;
  logic                w_cnt_load;
  logic [CntW-1:0]     w_cnt_val;
  logic                w_cnt_dec;
  logic                w_cnt_zero;
  logic                w_boundary;
  logic                w_host_xfer;

  assign w_boundary  = i_cpu_boundary | i_cpu_halted;
  assign w_host_xfer = (r_state == StLoad) && i_host_valid;

  arb_cycle_counter #(
    .W (CntW)
  ) u_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // Counter is loaded with DRAIN_MAX on DRAIN entry, so DRAIN lasts at most DRAIN_MAX+1
  // cycles; loaded with RST_CYCLES-1 on RELEASE entry so pc_rst is high RST_CYCLES cycles.
  always_comb begin
    w_state_d  = r_state;
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
    w_cnt_dec  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_load_req) begin
          w_state_d  = StDrain;
          w_cnt_load = 1'b1;
          w_cnt_val  = CntW'(DRAIN_MAX);
        end
      end
      StDrain: begin
        if (!i_load_req) begin
          w_state_d = StIdle;
        end else if (w_boundary || w_cnt_zero) begin
          w_state_d = StLoad;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      StLoad: begin
        if (!i_load_req) begin
          w_state_d  = StRelease;
          w_cnt_load = 1'b1;
          w_cnt_val  = CntW'(RST_CYCLES - 1);
        end
      end
      StRelease: begin
        if (w_cnt_zero) begin
          w_state_d = StIdle;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_load_grant <= 1'b0;
      r_pc_rst     <= 1'b0;
      r_load_count <= '0;
    end else begin
      r_state      <= w_state_d;
      r_load_grant <= (w_state_d == StLoad);
      r_pc_rst     <= (w_state_d == StRelease);
      if ((r_state != StLoad) && (w_state_d == StLoad)) begin
        r_load_count <= '0;
      end else if (w_host_xfer && (r_load_count != (ADDR_W + 1)'(Depth))) begin
        r_load_count <= r_load_count + (ADDR_W + 1)'(1);
      end
    end
  end

  // Hold asserts combinationally in DRAIN so the CPU freezes on the boundary cycle itself.
  always_comb begin
    o_cpu_hold   = 1'b0;
    o_host_ready = 1'b0;
    o_ram_addr   = i_cpu_addr;
    o_ram_wdata  = i_cpu_wdata;
    o_ram_we     = i_cpu_we;
    unique case (r_state)
      StIdle: ;
      StDrain: o_cpu_hold = w_boundary;
      StLoad: begin
        o_cpu_hold   = 1'b1;
        o_host_ready = 1'b1;
        o_ram_addr   = i_host_addr;
        o_ram_wdata  = i_host_data;
        o_ram_we     = w_host_xfer;
      end
      StRelease: begin
        o_cpu_hold  = 1'b1;
        o_ram_addr  = i_host_addr;
        o_ram_wdata = i_host_data;
        o_ram_we    = 1'b0;
      end
      default: ;
    endcase
  end

  assign o_load_grant = r_load_grant;
  assign o_pc_rst     = r_pc_rst;
  assign o_load_count = r_load_count;

endmodule

// File: tb/tb_prog_load_arbiter.sv
module tb_prog_load_arbiter;

  logic       clk;
  logic       rst;
  logic       load_req;
  logic       host_valid;
  logic [3:0] host_addr;
  logic [7:0] host_data;
  logic       host_ready;
  logic       load_grant;
  logic [4:0] load_count;
  logic       cpu_boundary;
  logic       cpu_halted;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_we;
  logic       cpu_hold;
  logic       pc_rst;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;

  logic [7:0] mem [16];

  int vectors;
  int miscompares;

  prog_load_arbiter #(
    .ADDR_W     (4),
    .DATA_W     (8),
    .RST_CYCLES (2),
    .DRAIN_MAX  (15)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_load_req     (load_req),
    .i_host_valid   (host_valid),
    .i_host_addr    (host_addr),
    .i_host_data    (host_data),
    .o_host_ready   (host_ready),
    .o_load_grant   (load_grant),
    .o_load_count   (load_count),
    .i_cpu_boundary (cpu_boundary),
    .i_cpu_halted   (cpu_halted),
    .i_cpu_addr     (cpu_addr),
    .i_cpu_wdata    (cpu_wdata),
    .i_cpu_we       (cpu_we),
    .o_cpu_hold     (cpu_hold),
    .o_pc_rst       (pc_rst),
    .o_ram_addr     (ram_addr),
    .o_ram_wdata    (ram_wdata),
    .o_ram_we       (ram_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program RAM model driven by the muxed RAM port.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    load_req     = 1'b0;
    host_valid   = 1'b0;
    host_addr    = 4'h0;
    host_data    = 8'h00;
    cpu_boundary = 1'b0;
    cpu_halted   = 1'b0;
    cpu_addr     = 4'h5;
    cpu_wdata    = 8'h00;
    cpu_we       = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state and CPU pass-through.
    chk("rst_grant", 32'(load_grant), 32'h0);
    chk("rst_count", 32'(load_count), 32'h0);
    chk("rst_hold", 32'(cpu_hold), 32'h0);
    chk("rst_pcrst", 32'(pc_rst), 32'h0);
    chk("rst_ready", 32'(host_ready), 32'h0);
    chk("idle_addr", 32'(ram_addr), 32'h5);

    // Request with boundary present: hold in DRAIN, grant one edge later.
    load_req     = 1'b1;
    cpu_boundary = 1'b1;
    step();
    chk("drain_hold", 32'(cpu_hold), 32'h1);
    chk("drain_grant", 32'(load_grant), 32'h0);
    step();
    cpu_boundary = 1'b0;
    chk("bnd_grant", 32'(load_grant), 32'h1);
    chk("bnd_ready", 32'(host_ready), 32'h1);
    host_valid = 1'b1;
    host_addr  = 4'h0;
    host_data  = 8'h1E;
    #1;
    chk("wr_we", 32'(ram_we), 32'h1);
    chk("wr_data", 32'(ram_wdata), 32'h1E);
    step();
    host_addr = 4'h1;
    host_data = 8'h2F;
    step();
    host_valid = 1'b0;
    chk("cnt2", 32'(load_count), 32'h2);
    chk("mem0", 32'(mem[0]), 32'h1E);
    chk("mem1", 32'(mem[1]), 32'h2F);

    // CPU write during LOAD is blocked.
    cpu_we    = 1'b1;
    cpu_addr  = 4'h1;
    cpu_wdata = 8'hAA;
    #1;
    chk("blk_we", 32'(ram_we), 32'h0);
    step();
    cpu_we = 1'b0;
    chk("blk_mem1", 32'(mem[1]), 32'h2F);

    // Release: pc_rst high for exactly 2 cycles, then CPU owns RAM again.
    load_req = 1'b0;
    cpu_addr = 4'h9;
    step();
    chk("rel_pcrst1", 32'(pc_rst), 32'h1);
    chk("rel_hold", 32'(cpu_hold), 32'h1);
    step();
    chk("rel_pcrst2", 32'(pc_rst), 32'h1);
    step();
    chk("rel_pcrst3", 32'(pc_rst), 32'h0);
    chk("rel_hold_off", 32'(cpu_hold), 32'h0);
    chk("rel_addr", 32'(ram_addr), 32'h9);
    chk("rel_count", 32'(load_count), 32'h2);

    // No boundary: forced grant after DRAIN_MAX+1 cycles in DRAIN.
    load_req = 1'b1;
    step();
    chk("to_hold", 32'(cpu_hold), 32'h0);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("to_wait", 32'(load_grant), 32'h0);
    end
    step();
    chk("to_grant", 32'(load_grant), 32'h1);
    chk("to_count_clr", 32'(load_count), 32'h0);

    // 17 writes: addresses 0..F then 0 again; count saturates at 16.
    host_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      host_addr = 4'(i);
      host_data = 8'(8'h40 + i);
      step();
      if (i == 15) chk("cnt16", 32'(load_count), 32'h10);
    end
    host_valid = 1'b0;
    chk("cnt_sat", 32'(load_count), 32'h10);
    chk("mem0_last", 32'(mem[0]), 32'h50);
    chk("memF", 32'(mem[15]), 32'h4F);

    // load_req re-raised during RELEASE only takes effect from IDLE.
    load_req = 1'b0;
    step();
    load_req = 1'b1;
    step();
    chk("rr_pcrst", 32'(pc_rst), 32'h1);
    step();
    chk("rr_idle_pc", 32'(pc_rst), 32'h0);
    chk("rr_idle_grant", 32'(load_grant), 32'h0);
    cpu_halted = 1'b1;
    step();
    chk("rr_drain_hold", 32'(cpu_hold), 32'h1);
    step();
    cpu_halted = 1'b0;
    chk("rr_grant", 32'(load_grant), 32'h1);
    chk("rr_cnt_clr", 32'(load_count), 32'h0);

    // Reset mid-LOAD after 3 writes.
    host_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      host_addr = 4'(i + 4);
      host_data = 8'(i);
      step();
    end
    host_valid = 1'b0;
    chk("pre_rst_cnt", 32'(load_count), 32'h3);
    load_req = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_grant", 32'(load_grant), 32'h0);
    chk("arst_count", 32'(load_count), 32'h0);
    chk("arst_hold", 32'(cpu_hold), 32'h0);
    chk("arst_pcrst", 32'(pc_rst), 32'h0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_pcrst", 32'(pc_rst), 32'h0);

    // Drain abort: dropping load_req in DRAIN returns to IDLE without a pulse.
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    step();
    chk("abort_grant", 32'(load_grant), 32'h0);
    chk("abort_pcrst", 32'(pc_rst), 32'h0);
    step();
    chk("abort_pcrst2", 32'(pc_rst), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
